// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings,
// the HALT instruction and the byte-to-word geometry.
package imem_load_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
  localparam int unsigned BYTES_PER_WORD    = 4;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Byte stream from the debug unit into the loader (valid/ready handshake).
interface imem_load_ctrl_if;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);

endinterface

// File: rtl/imem_load_ctrl_byte_packer.sv
// Big-endian byte packer: shifts bytes into a 32-bit word, first byte ends
// up as the MSB; word_valid marks the strobe that completes a word.
module byte_packer
  import imem_load_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_data,
  input  logic        strobe,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  // clear wins over strobe so a byte arriving with a restart is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      word     <= '0;
    end else if (strobe) begin
      byte_cnt <= byte_cnt + 2'd1;
      word     <= {word[23:0], byte_data};
    end
  end

  assign word_valid = strobe && !clear && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: packs debug-unit bytes into words,
// writes them from address 0 until HALT, then hands the port to fetch.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = 9,
  parameter int unsigned ADDR_LENGTH = 32,
  parameter int unsigned DATA_LENGTH = 32,
  parameter logic [31:0] HALT_WORD   = HALT_WORD_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_load_start,
  imem_load_ctrl_if.slave        byte_if,
  input  logic [ADDR_LENGTH-1:0] i_fetch_addr,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic [DATA_LENGTH-1:0] o_mem_wdata,
  output logic                   o_mem_we,
  output logic                   o_cpu_stall,
  output logic                   o_load_done,
  output logic                   o_load_err,
  output logic [MEM_SIZE:0]      o_word_count
);

  localparam logic [MEM_SIZE-1:0] LAST_ADDR = '1;
  localparam logic [MEM_SIZE:0]   COUNT_MAX = {1'b1, {MEM_SIZE{1'b0}}};

  logic [2:0]          state;
  logic [MEM_SIZE-1:0] word_addr;
  logic [MEM_SIZE:0]   word_count;
  logic [31:0]         asm_word;
  logic                word_valid;
  logic                restart;
  logic                strobe;

  // WRITE is a single committed cycle; a restart request there is ignored
  assign restart = i_load_start && (state != ST_WRITE);
  assign strobe  = byte_if.byte_valid && byte_if.byte_ready && !i_load_start;

  byte_packer u_packer (
    .clk        (i_clk),
    .rst        (i_rst),
    .clear      (restart),
    .byte_data  (byte_if.byte_data),
    .strobe     (strobe),
    .word       (asm_word),
    .word_valid (word_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      word_count <= '0;
    end else if (restart) begin
      state      <= ST_LOAD;
      word_addr  <= '0;
      word_count <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (word_valid) state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (word_count != COUNT_MAX) word_count <= word_count + 1'b1;
          if (asm_word == HALT_WORD) begin
            state <= ST_DONE;
          end else if (word_addr == LAST_ADDR) begin
            state <= ST_ERROR;
          end else begin
            word_addr <= word_addr + 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: state <= state;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_if.byte_ready = (state == ST_LOAD);
    o_mem_we           = (state == ST_WRITE);
    o_mem_wdata        = o_mem_we ? DATA_LENGTH'(asm_word) : '0;
    o_mem_addr         = (state == ST_DONE) ? i_fetch_addr : ADDR_LENGTH'(word_addr);
    o_cpu_stall        = (state != ST_DONE);
    o_load_done        = (state == ST_DONE);
    o_load_err         = (state == ST_ERROR);
    o_word_count       = word_count;
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: a program-level model predicts the
// (address, data) writes; a monitor checks every write strobe against it.
module tb_imem_load_ctrl;
  import imem_load_ctrl_pkg::*;

  localparam int MEM_SIZE = 9;
  localparam int DEPTH    = 1 << MEM_SIZE;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [MEM_SIZE:0] word_count;

  imem_load_ctrl_if bus ();

  imem_load_ctrl #(
    .MEM_SIZE    (MEM_SIZE),
    .ADDR_LENGTH (32),
    .DATA_LENGTH (32),
    .HALT_WORD   (HALT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_load_start (load_start),
    .byte_if      (bus.slave),
    .i_fetch_addr (fetch_addr),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_we     (mem_we),
    .o_cpu_stall  (cpu_stall),
    .o_load_done  (load_done),
    .o_load_err   (load_err),
    .o_word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // program-level model: words land at consecutive addresses from 0 until
  // HALT is written or the last address is used
  logic [31:0] model_addr;
  int          model_count;
  bit          model_stopped;
  bit          model_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_addr    = '0;
    model_count   = 0;
    model_stopped = 0;
    model_err     = 0;
  endtask

  task automatic expect_word(input logic [31:0] d);
    wr_t w;
    if (!model_stopped) begin
      w.addr = model_addr;
      w.data = d;
      exp_q.push_back(w);
      model_count++;
      if (d == HALT) begin
        model_stopped = 1;
      end else if (model_addr == DEPTH - 1) begin
        model_stopped = 1;
        model_err     = 1;
      end else begin
        model_addr++;
      end
    end
  endtask

  // monitor: every write strobe must match the next predicted write
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (prev_we) begin
        total++; bad++;
        $display("FAIL we_width: write strobe high two cycles in a row at addr %0h", mem_addr);
      end
      chk("ready_in_write", bus.byte_ready, 1'b0);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
    end
    prev_we = mem_we;
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (!bus.byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.byte_ready) begin
      total++; bad++;
      $display("FAIL byte_accept_timeout: ready %0b expected 1 within 100 cycles", bus.byte_ready);
    end else begin
      @(posedge clk);
    end
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] d, input int unsigned max_gap);
    expect_word(d);
    for (int i = 0; i < 4; i++)
      send_byte(d[31 - 8*i -: 8], $urandom_range(max_gap, 0));
  endtask

  task automatic send_word_fixed_gap(input logic [31:0] d, input int unsigned gap);
    expect_word(d);
    for (int i = 0; i < 4; i++) send_byte(d[31 - 8*i -: 8], gap);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending_writes", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, cpu_stall, 1'b1);
    chk({tag, "_ready"}, bus.byte_ready, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_done"}, load_done, 1'b0);
    chk({tag, "_err"}, load_err, 1'b0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_count"}, word_count, 0);
  endtask

  task automatic check_done();
    chk("done_flag", load_done, 1'b1);
    chk("done_stall", cpu_stall, 1'b0);
    chk("done_err", load_err, 1'b0);
    chk("done_count", word_count, model_count);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] f;
    int unsigned nw;

    rst            = 1'b1;
    load_start     = 1'b0;
    fetch_addr     = 32'h0;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // idle: no load requested, CPU held, no handshake
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_stall", cpu_stall, 1'b1);
      chk("idle_ready", bus.byte_ready, 1'b0);
      chk("idle_we", mem_we, 1'b0);
    end

    // directed two-word program, back-to-back bytes
    pulse_start();
    chk("load_ready", bus.byte_ready, 1'b1);
    chk("load_stall", cpu_stall, 1'b1);
    send_word(32'h2008_0005, 0);
    send_word(HALT, 0);
    drain();
    check_done();
    chk("done_ready", bus.byte_ready, 1'b0);
    fetch_addr = 32'd7;
    #1 chk("fetch_passthrough_7", mem_addr, 32'd7);
    for (int i = 0; i < 4; i++) begin
      f = $urandom;
      @(negedge clk);
      fetch_addr = f;
      #1 chk("fetch_passthrough", mem_addr, f);
    end

    // same program, one byte every 3 cycles
    pulse_start();
    chk("reload_done_clear", load_done, 1'b0);
    chk("reload_count_clear", word_count, 0);
    send_word_fixed_gap(32'h2008_0005, 2);
    send_word_fixed_gap(HALT, 2);
    drain();
    check_done();

    // random program with random gaps
    pulse_start();
    nw = $urandom_range(8, 3);
    for (int unsigned i = 0; i < nw; i++) begin
      d = $urandom;
      if (d == HALT) d = 32'h1234_5678;
      send_word(d, 3);
    end
    send_word(HALT, 3);
    drain();
    check_done();

    // overflow: a full memory of non-HALT words
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      if (d == HALT) d = 32'h0;
      send_word(d, 0);
    end
    drain();
    chk("overflow_model", model_err, 1'b1);
    chk("err_flag", load_err, 1'b1);
    chk("err_stall", cpu_stall, 1'b1);
    chk("err_done", load_done, 1'b0);
    chk("err_count", word_count, DEPTH);
    repeat (5) @(negedge clk);
    chk("err_sticky", load_err, 1'b1);
    chk("err_ready", bus.byte_ready, 1'b0);
    pulse_start();
    chk("err_cleared", load_err, 1'b0);
    chk("err_restart_count", word_count, 0);
    send_word(32'hCAFE_0001, 1);
    send_word(HALT, 1);
    drain();
    check_done();

    // restart mid-word: partial word and a same-cycle byte are discarded
    pulse_start();
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3333, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    drain();
    chk("partial_count", word_count, 3);
    @(negedge clk);
    load_start     = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    @(negedge clk);
    load_start     = 1'b0;
    bus.byte_valid = 1'b0;
    model_reset();
    chk("restart_count", word_count, 0);
    chk("restart_ready", bus.byte_ready, 1'b1);
    send_word(32'h4455_6677, 0);
    send_word(HALT, 0);
    drain();
    check_done();

    // asynchronous reset mid-LOAD, then in DONE
    pulse_start();
    send_word(32'h0BAD_F00D, 0);
    send_byte(8'h01, 0);
    drain();
    pulse_reset("rst_load");
    @(negedge clk);
    chk("post_rst_idle_stall", cpu_stall, 1'b1);
    chk("post_rst_idle_ready", bus.byte_ready, 1'b0);
    pulse_start();
    send_word(32'h0000_0013, 0);
    send_word(HALT, 0);
    drain();
    check_done();
    fetch_addr = 32'h55;
    pulse_reset("rst_done");
    pulse_start();
    send_word(32'hABCD_EF01, 2);
    send_word(HALT, 0);
    drain();
    check_done();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
- Owns the write side of instruction_memory.
- Arbitrates the memory address port between the debug-unit byte loader and the fetch-stage PC.
- Assembles incoming UART bytes into 32-bit instructions, writes them at consecutive word addresses, and stops loading on the HALT word.
- Holds the CPU stalled until a program is fully loaded, then hands the address port to fetch.

Parameters:
MEM_SIZE, 9, log2 of memory depth in words (512 words)
ADDR_LENGTH, 32, width of memory/fetch address bus (word index)
DATA_LENGTH, 32, instruction word width; fixed at 32 (4 bytes per word)
HALT_WORD, 32'hFFFFFFFF, instruction that terminates a load

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_rst  in  1  reset, asynchronous, active-high
i_load_start  in  1  single-cycle request to begin a (re)load
i_byte  in  8  program byte from the debug unit
i_byte_valid  in  1  i_byte holds a valid byte
o_byte_ready  out  1  controller accepts a byte this cycle
i_fetch_addr  in  ADDR_LENGTH  fetch-stage word address
o_mem_addr  out  ADDR_LENGTH  address to instruction_memory
o_mem_wdata  out  DATA_LENGTH  write data to instruction_memory
o_mem_we  out  1  write enable to instruction_memory
o_cpu_stall  out  1  high = pipeline must not advance
o_load_done  out  1  program loaded, CPU running
o_load_err  out  1  memory overflow before HALT seen
o_word_count  out  MEM_SIZE+1  words written in the current load, HALT included

Behaviour:
- Reset (async, i_rst=1):
  - State IDLE; byte_cnt=0, word_addr=0, asm_word=0, o_word_count=0.
  - Outputs: o_mem_we=0, o_mem_wdata=0, o_mem_addr=0, o_byte_ready=0, o_cpu_stall=1, o_load_done=0, o_load_err=0.
- States: IDLE, LOAD, WRITE, DONE, ERROR.
- IDLE:
  - o_cpu_stall=1, o_byte_ready=0.
  - i_load_start -> LOAD; clears counters and o_word_count.
- LOAD:
  - o_byte_ready=1. A byte transfers on the cycle i_byte_valid & o_byte_ready.
  - On each transfer: asm_word <= {asm_word[23:0], i_byte}, so the first byte is the MSB (big-endian); byte_cnt++.
  - Transfer with byte_cnt==3 -> WRITE; byte_cnt wraps to 0.
  - i_load_start in LOAD restarts: partial word discarded, word_addr=0, o_word_count=0; a byte presented in the same cycle is dropped.
- WRITE (exactly 1 cycle):
  - o_mem_we=1, o_mem_addr=word_addr, o_mem_wdata=asm_word, o_byte_ready=0; o_word_count++.
  - If asm_word==HALT_WORD -> DONE (HALT itself is written).
  - Else if word_addr==2**MEM_SIZE-1 -> ERROR.
  - Else word_addr++ and -> LOAD.
  - i_load_start in WRITE is ignored.
- Latency:
  - 4th byte accepted at edge N; write strobe visible in cycle N..N+1.
  - Next byte accepted no earlier than edge N+2.
  - Maximum throughput is 1 word per 5 cycles.
- DONE:
  - o_cpu_stall=0, o_load_done=1, o_mem_we=0.
  - o_mem_addr=i_fetch_addr, combinational pass-through, no added latency.
  - i_load_start -> LOAD; o_cpu_stall=1 and o_load_done=0 from the next cycle.
- ERROR:
  - o_load_err=1, o_cpu_stall=1, o_mem_we=0.
  - Only i_load_start (-> LOAD, clears o_load_err) or reset exits.
- Outside DONE:
  - o_mem_addr=word_addr; fetch address is ignored.
  - o_mem_we is only ever high in WRITE.
- Reset mid-operation: immediate return to reset values. Memory contents are not cleared; o_load_done=0 prevents execution of the stale program.
- o_word_count saturates at 2**MEM_SIZE (cannot exceed it given ERROR).

Decomposition:
- Shared package (cpu_pkg) holds:
  - state enum/localparams IDLE..ERROR
  - HALT_WORD constant
  - BYTES_PER_WORD=4
- One natural sub-module: byte_packer.
  - Shift register plus 2-bit counter.
  - Ports: clear, byte, strobe, word, word_valid.
  - Reusable for the data-memory dump path.
- FSM, address counter and port mux stay in imem_load_ctrl.

Test Plan:
- Reset release, no load_start for 20 cycles -> o_cpu_stall=1, o_byte_ready=0, o_mem_we=0 throughout.
- load_start, then bytes 20,08,00,05 and FF,FF,FF,FF -> we at addr 0 data 32'h20080005, then addr 1 data 32'hFFFFFFFF; DONE; o_word_count=2; o_cpu_stall=0; o_mem_addr follows i_fetch_addr=7 in the same cycle.
- Gapped valid (1 byte every 3 cycles, back-pressure checked) -> identical memory writes; no byte lost or duplicated; each write is exactly 1-cycle wide.
- 512 non-HALT words -> 512 writes at addresses 0..511; ERROR; o_load_err=1; stall stays high; then load_start clears o_load_err and loads from address 0.
- load_start after 2 bytes of word 3 -> partial discarded; next full word written at addr 0; o_word_count restarts from 0.
- Assert i_rst for 1 cycle mid-LOAD and again in DONE -> all outputs return to reset values asynchronously; subsequent load behaves as fresh.
